// File: rtl/decoder_n_scan_pkg.sv
// Shared types, mode encodings and the MSB-first one-hot helper for decoder_n_scan.
package decoder_n_scan_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SCAN} state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest select bus the helper can build (SEL_W up to 8).
  localparam int unsigned MAX_OUT_W = 256;

  // Code k sets bit width-1-k; out-of-range codes give all-zero.
  function automatic logic [MAX_OUT_W-1:0] onehot_msb(input int unsigned code,
                                                      input int unsigned width);
    logic [MAX_OUT_W-1:0] r;
    r = '0;
    if (code < width && width <= MAX_OUT_W) begin
      r = MAX_OUT_W'(1) << (width - 1 - code);
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_n_scan_if.sv
// Code handshake between the controlling logic (master) and decoder_n_scan (slave).
interface decoder_n_scan_if #(
  parameter int unsigned SEL_W = 2
) ();

  logic [SEL_W-1:0] code_in;
  logic             code_vld;
  logic             code_rdy;

  modport master (output code_in, output code_vld, input code_rdy);
  modport slave  (input code_in, input code_vld, output code_rdy);

endinterface

// File: rtl/scan_prescaler.sv
// Scan-rate prescaler: counts 0..PRESCALE-1 and flags the terminal count.
module scan_prescaler #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned PRE_W    = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == PRE_W'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q + PRE_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N one-hot decoder with DIRECT (handshake) and SCAN (free-running) modes.
// Optional DECODER_N_SCAN_BLANK_EN inserts one all-zero cycle before every select change.
module decoder_n_scan
  import decoder_n_scan_pkg::*;
#(
  parameter int unsigned  SEL_W    = 2,
  parameter int unsigned  PRESCALE = 50000,
  parameter int unsigned  PRE_W    = 24,
  localparam int unsigned OUT_W    = 2 ** SEL_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   mode,
  decoder_n_scan_if.slave        code_if,
  output logic [OUT_W-1:0]       y,
  output logic [SEL_W-1:0]       cur_code,
  output logic                   step
);

  function automatic logic [OUT_W-1:0] oh(input logic [SEL_W-1:0] c);
    return OUT_W'(onehot_msb(32'(c), OUT_W));
  endfunction

  state_e           state_q, state_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic [SEL_W-1:0] cur_q, cur_d, upd_code;
  logic             step_q, step_d;
  logic             rdy_q, rdy_d;
  logic             stay_scan, clr, tick, adv, fire, upd;

  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
    end
  end

  // Any exit from or entry into SCAN restarts the step period.
  assign stay_scan = (state_q == ST_SCAN) && (state_d == ST_SCAN);
  assign clr       = !stay_scan;
  assign adv       = stay_scan && tick;
  assign fire      = code_if.code_vld && rdy_q && (state_d == ST_DIRECT);

  scan_prescaler #(
    .PRESCALE (PRESCALE),
    .PRE_W    (PRE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

`ifdef DECODER_N_SCAN_BLANK_EN
  logic blank_q, blank_d;
`endif

  always_comb begin
    y_d      = y_q;
    cur_d    = cur_q;
    step_d   = 1'b0;
    upd      = 1'b0;
    upd_code = cur_q;
`ifdef DECODER_N_SCAN_BLANK_EN
    blank_d  = 1'b0;
    if (blank_q) begin
      y_d = oh(cur_q);
    end
`endif
    if (adv) begin
      upd      = 1'b1;
      upd_code = cur_q + SEL_W'(1);
      step_d   = 1'b1;
    end else if (fire) begin
      upd      = 1'b1;
      upd_code = code_if.code_in;
    end else if (state_d == ST_SCAN && state_q != ST_SCAN) begin
      y_d = oh(cur_q);
    end

    if (upd) begin
      cur_d = upd_code;
`ifdef DECODER_N_SCAN_BLANK_EN
      // Re-selecting the code already shown needs no blanking cycle.
      if (upd_code != cur_q || y_q == '0) begin
        y_d     = '0;
        blank_d = 1'b1;
      end
`else
      y_d = oh(upd_code);
`endif
    end

    if (state_d == ST_IDLE) begin
      y_d     = '0;
      cur_d   = '0;
`ifdef DECODER_N_SCAN_BLANK_EN
      blank_d = 1'b0;
`endif
    end

`ifdef DECODER_N_SCAN_BLANK_EN
    rdy_d = (state_d == ST_DIRECT) && !blank_d;
`else
    rdy_d = (state_d == ST_DIRECT);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      cur_q   <= '0;
      step_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cur_q   <= cur_d;
      step_q  <= step_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef DECODER_N_SCAN_BLANK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end
`endif

  assign y                = y_q;
  assign cur_code         = cur_q;
  assign step             = step_q;
  assign code_if.code_rdy = rdy_q;

endmodule
